// File: rtl/btn_conditioner.sv
// Push-button conditioner: sync, debounce, press pulse, hold-to-repeat and
// one-hot direction arbitration for the five board buttons.

// One button: 2-flop sync, polarity-normalizing level register, debouncer,
// and optional auto-repeat. 'due' flags a pulse that the top may output.
module btn_lane #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_RATE     = 3750000,
    parameter int ACTIVE_LOW      = 1,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic held,
    output logic due
);

    localparam logic [23:0] DB_LAST   = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] RPT_FIRST = 24'(REPEAT_DELAY);
    localparam logic [23:0] RPT_NEXT  = 24'(REPEAT_RATE);
    // Released pin level, so reset never looks like a press edge.
    localparam logic        IDLE_PIN  = (ACTIVE_LOW != 0);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        lvl_q, lvl_d;
    logic        held_q, held_d;
    logic        armed_q, armed_d;
    logic [23:0] db_cnt_q, db_cnt_d;
    logic [23:0] rpt_cnt_q, rpt_cnt_d;
    logic [23:0] rpt_inc, rpt_target;
    logic        rpt_due;

    // Synchronizer chain; level register holds 1 = pressed regardless of pin polarity.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        lvl_d   = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    end

    // Debounce: accept a new level only after it persists DEBOUNCE_CYCLES cycles.
    always_comb begin
        held_d   = held_q;
        db_cnt_d = '0;
        if (lvl_q != held_q) begin
            if (db_cnt_q == DB_LAST) begin
                held_d   = ~held_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 24'd1;
            end
        end
    end

    // Auto-repeat: first pulse after REPEAT_DELAY, then every REPEAT_RATE.
    // Counts only while held stays up; a rise or a fall clears it.
    always_comb begin
        rpt_inc    = rpt_cnt_q + 24'd1;
        rpt_target = armed_q ? RPT_NEXT : RPT_FIRST;
        rpt_cnt_d  = '0;
        armed_d    = 1'b0;
        rpt_due    = 1'b0;
        if (REPEAT_EN && held_q && held_d) begin
            if (rpt_inc == rpt_target) begin
                rpt_due   = 1'b1;
                rpt_cnt_d = '0;
                armed_d   = 1'b1;
            end else begin
                rpt_cnt_d = rpt_inc;
                armed_d   = armed_q;
            end
        end
    end

    // Pulse request: debounced press edge or a repeat tick (top registers it).
    always_comb begin
        due  = (held_d & ~held_q) | rpt_due;
        held = held_q;
    end

    // Lane state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= IDLE_PIN;
            sync2_q   <= IDLE_PIN;
            lvl_q     <= 1'b0;
            held_q    <= 1'b0;
            armed_q   <= 1'b0;
            db_cnt_q  <= '0;
            rpt_cnt_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            lvl_q     <= lvl_d;
            held_q    <= held_d;
            armed_q   <= armed_d;
            db_cnt_q  <= db_cnt_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

endmodule

module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_RATE     = 3750000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    output logic       btn_up,
    output logic       btn_down,
    output logic       btn_left,
    output logic       btn_right,
    output logic       selected,
    output logic [4:0] held
);

    logic [4:0] due;
    logic [3:0] dir_q, dir_d;
    logic       sel_q, sel_d;

    // Bits 0-3 are directions and repeat; bit 4 (select) never repeats.
    for (genvar i = 0; i < 5; i++) begin : g_lane
        btn_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE),
            .ACTIVE_LOW     (ACTIVE_LOW),
            .REPEAT_EN      (i < 4)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .raw (btn_raw[i]),
            .held(held[i]),
            .due (due[i])
        );
    end

    // Fixed priority up > down > left > right; losers are dropped, and their
    // repeat counters have already reloaded inside the lane.
    always_comb begin
        dir_d = 4'b0000;
        if (due[0])      dir_d = 4'b0001;
        else if (due[1]) dir_d = 4'b0010;
        else if (due[2]) dir_d = 4'b0100;
        else if (due[3]) dir_d = 4'b1000;
        sel_d = due[4];
    end

    // Registered pulse outputs; reset kills any pending pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q <= '0;
            sel_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
            sel_q <= sel_d;
        end
    end

    assign btn_up    = dir_q[0];
    assign btn_down  = dir_q[1];
    assign btn_left  = dir_q[2];
    assign btn_right = dir_q[3];
    assign selected  = sel_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE=4, REPEAT_DELAY=20,
// REPEAT_RATE=8, active-low pins. Each loop index e is the clock edge count
// since the scenario's first drive; outputs are sampled on the falling edge.
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn_raw;
    logic       btn_up, btn_down, btn_left, btn_right, selected;
    logic [4:0] held;
    logic [9:0] obs;
    logic [4:0] h, p;

    int checks   = 0;
    int failures = 0;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_RATE    (8),
        .ACTIVE_LOW     (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .selected (selected),
        .held     (held)
    );

    always #5 clk = ~clk;

    // {held, selected, right, left, down, up}
    assign obs = {held, selected, btn_right, btn_left, btn_down, btn_up};

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = 5'h1F;
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            chk($sformatf("reset e%0d", e), obs, 10'h000);
        end
        rst = 1'b0;
        for (int e = 0; e < 5; e++) begin
            @(negedge clk);
            chk($sformatf("idle e%0d", e), obs, 10'h000);
        end

        // Clean press of up, released before any repeat.
        for (int e = 0; e < 30; e++) begin
            btn_raw = (e < 15) ? 5'h1E : 5'h1F;
            @(negedge clk);
            h = '0; p = '0;
            h[0] = (e >= 6 && e < 21);
            p[0] = (e == 6);
            chk($sformatf("press e%0d", e), obs, {h, p});
        end

        // Bounce on left: 3-cycle runs never qualify.
        for (int t = 0; t < 30; t++) begin
            btn_raw = (((t / 3) % 2) == 0) ? 5'h1B : 5'h1F;
            @(negedge clk);
            chk($sformatf("bounce t%0d", t), obs, 10'h000);
        end
        for (int e = 0; e < 24; e++) begin
            btn_raw = (e < 12) ? 5'h1B : 5'h1F;
            @(negedge clk);
            h = '0; p = '0;
            h[2] = (e >= 6 && e < 18);
            p[2] = (e == 6);
            chk($sformatf("settle e%0d", e), obs, {h, p});
        end

        // Right and select held together: right repeats, select does not.
        for (int e = 0; e < 80; e++) begin
            btn_raw = (e < 64) ? 5'h07 : 5'h1F;
            @(negedge clk);
            h = '0; p = '0;
            h[3] = (e >= 6 && e < 70);
            h[4] = h[3];
            p[4] = (e == 6);
            p[3] = (e == 6) || (e >= 26 && e <= 66 && ((e - 26) % 8) == 0);
            chk($sformatf("repeat e%0d", e), obs, {h, p});
        end

        // Up and down together: down is dropped until up lets go, and its
        // repeat phase keeps running as if it had pulsed.
        for (int e = 0; e < 76; e++) begin
            btn_raw = 5'h1F;
            if (e < 40) btn_raw[0] = 1'b0;
            if (e < 60) btn_raw[1] = 1'b0;
            @(negedge clk);
            h = '0; p = '0;
            h[0] = (e >= 6 && e < 46);
            h[1] = (e >= 6 && e < 66);
            p[0] = (e == 6) || (e == 26) || (e == 34) || (e == 42);
            p[1] = (e == 50) || (e == 58);
            chk($sformatf("arb e%0d", e), obs, {h, p});
        end

        // Reset for 3 cycles while down is held: re-detected as a new press.
        for (int e = 0; e < 48; e++) begin
            btn_raw = (e < 35) ? 5'h1D : 5'h1F;
            rst     = (e >= 20 && e < 23);
            @(negedge clk);
            h = '0; p = '0;
            h[1] = (e >= 6 && e < 20) || (e >= 29 && e < 41);
            p[1] = (e == 6) || (e == 29);
            chk($sformatf("rsthold e%0d", e), obs, {h, p});
        end

        // Reset asserted on the pulse cycle.
        for (int e = 0; e < 32; e++) begin
            btn_raw = (e < 20) ? 5'h1E : 5'h1F;
            rst     = (e == 7);
            @(negedge clk);
            h = '0; p = '0;
            h[0] = (e == 6) || (e >= 14 && e < 26);
            p[0] = (e == 6) || (e == 14);
            chk($sformatf("rstpulse e%0d", e), obs, {h, p});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
